// File: rtl/swan256_arbiter.sv
// swan256_arbiter
// Round-robin scheduler sharing one SWAN256 encrypt core and one SWAN256
// decrypt core between NREQ requesters. One 256-bit operation is in flight
// at a time: IDLE grants and captures, LAUNCH pulses the selected core's
// start, BUSY waits for that core's ready, RESP holds the result until the
// consumer takes it.
//
// Optional feature: define SWAN256_ARB_TIMEOUT_EN to add a BUSY watchdog.
// After TIMEOUT_CYC BUSY cycles without ready the FSM passes through ABORT
// (one cycle of core_rst=0) and answers with rsp_err=1, rsp_data=0.
module swan256_arbiter #(
  parameter int NREQ        = 4,
  parameter int BLOCK_SIZE  = 256,
  parameter int KEY_SIZE    = 256,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_dec,
  input  logic [NREQ*KEY_SIZE-1:0]   req_key,
  input  logic [NREQ*BLOCK_SIZE-1:0] req_inp,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [BLOCK_SIZE-1:0]      rsp_data,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       rsp_err,
  output logic                       core_rst,
  output logic [KEY_SIZE-1:0]        core_key,
  output logic [BLOCK_SIZE-1:0]      core_inp,
  output logic                       core_enc_start,
  output logic                       core_dec_start,
  input  logic                       core_enc_ready,
  input  logic                       core_dec_ready,
  input  logic [BLOCK_SIZE-1:0]      core_enc_out,
  input  logic [BLOCK_SIZE-1:0]      core_dec_out
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
`ifdef SWAN256_ARB_TIMEOUT_EN
    ST_RESP,
    ST_ABORT
`else
    ST_RESP
`endif
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       id_q;
  logic                  dec_q;
  logic [KEY_SIZE-1:0]   key_q;
  logic [BLOCK_SIZE-1:0] inp_q;

  logic [ID_W-1:0]       grant;
  logic                  grant_found;
  logic                  sel_ready;

`ifdef SWAN256_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] busy_cnt;
  logic             err_q;
`endif

  // Pick the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  // Accept is offered only in IDLE and never while reset is asserted.
  assign req_ready = (state == ST_IDLE && grant_found && rst) ? (NREQ'(1) << grant) : '0;

  // Only the core that was launched is allowed to finish the operation.
  assign sel_ready = dec_q ? core_dec_ready : core_enc_ready;

  assign core_key = key_q;
  assign core_inp = inp_q;
  assign rsp_id   = id_q;

`ifdef SWAN256_ARB_TIMEOUT_EN
  assign rsp_err  = err_q;
  assign core_rst = rst & (state != ST_ABORT);
`else
  assign rsp_err  = 1'b0;
  assign core_rst = rst;
`endif

  // Scheduler FSM: capture on grant, pulse start, wait for ready, hold response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      id_q           <= '0;
      dec_q          <= 1'b0;
      // NOTE: the wide capture registers are reset because core_key/core_inp must read 0 out of reset.
      key_q          <= '0;
      inp_q          <= '0;
      core_enc_start <= 1'b0;
      core_dec_start <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
`ifdef SWAN256_ARB_TIMEOUT_EN
      busy_cnt       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking (<=) so all of them sample pre-edge values.
      core_enc_start <= 1'b0;
      core_dec_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            key_q          <= req_key[grant*KEY_SIZE +: KEY_SIZE];
            inp_q          <= req_inp[grant*BLOCK_SIZE +: BLOCK_SIZE];
            dec_q          <= req_dec[grant];
            id_q           <= grant;
            rr_ptr         <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
            core_enc_start <= ~req_dec[grant];
            core_dec_start <= req_dec[grant];
            state          <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // A ready seen here belongs to an earlier operation and is ignored.
`ifdef SWAN256_ARB_TIMEOUT_EN
          busy_cnt <= '0;
`endif
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (sel_ready) begin
            rsp_data  <= dec_q ? core_dec_out : core_enc_out;
            rsp_valid <= 1'b1;
`ifdef SWAN256_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state     <= ST_RESP;
          end
`ifdef SWAN256_ARB_TIMEOUT_EN
          else if (busy_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state <= ST_ABORT;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
`ifdef SWAN256_ARB_TIMEOUT_EN
        ST_ABORT: begin
          rsp_data  <= '0;
          err_q     <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swan256_arbiter.sv
// Directed testbench for swan256_arbiter. The two cipher cores are replaced
// by a behavioural model that answers from a small table of known
// key/plaintext/ciphertext triples after a fixed latency.
module tb_swan256_arbiter;

  localparam int NREQ        = 4;
  localparam int BLOCK_SIZE  = 256;
  localparam int KEY_SIZE    = 256;
  localparam int TIMEOUT_CYC = 64;

  localparam logic [255:0] KEY1 = {256{1'b1}};
  localparam logic [255:0] P1   = {4{64'hf0debc9a78563412}};
  localparam logic [255:0] C1   = 256'h5e7f7837ab855ba2666046be47c2b93a435db79615506e3128b7fd3d1a0f22c2;
  localparam logic [255:0] P2   = {4{64'h7856341278563412}};
  localparam logic [255:0] C2   = 256'h7bfc52c91831bb1925dfeb802f78e65949fca8b47b830fcb46b3b57620e3775c;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_dec = '0;
  logic [NREQ*KEY_SIZE-1:0]   req_key = '0;
  logic [NREQ*BLOCK_SIZE-1:0] req_inp = '0;
  logic [NREQ-1:0]            req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b0;
  logic [BLOCK_SIZE-1:0]      rsp_data;
  logic [1:0]                 rsp_id;
  logic                       rsp_err;
  logic                       core_rst;
  logic [KEY_SIZE-1:0]        core_key;
  logic [BLOCK_SIZE-1:0]      core_inp;
  logic                       core_enc_start;
  logic                       core_dec_start;
  logic                       core_enc_ready = 1'b0;
  logic                       core_dec_ready = 1'b0;
  logic [BLOCK_SIZE-1:0]      core_enc_out = '0;
  logic [BLOCK_SIZE-1:0]      core_dec_out = '0;

  int vectors     = 0;
  int miscompares = 0;

  swan256_arbiter #(
    .NREQ(NREQ), .BLOCK_SIZE(BLOCK_SIZE), .KEY_SIZE(KEY_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dec(req_dec), .req_key(req_key), .req_inp(req_inp),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_rst(core_rst), .core_key(core_key), .core_inp(core_inp),
    .core_enc_start(core_enc_start), .core_dec_start(core_dec_start),
    .core_enc_ready(core_enc_ready), .core_dec_ready(core_dec_ready),
    .core_enc_out(core_enc_out), .core_dec_out(core_dec_out)
  );

  always #5 clk = ~clk;

  // ---------------- core model ----------------
  int enc_lat = 3;
  int dec_lat = 3;
  bit stuck   = 1'b0;
  int enc_cnt = 0;
  int dec_cnt = 0;
  logic [255:0] enc_res, dec_res;
  logic         s_rst, s_enc, s_dec;
  logic [255:0] s_key, s_inp;

  function automatic logic [255:0] enc_lookup(input logic [255:0] k, input logic [255:0] p);
    if (k == KEY1 && p == P1) return C1;
    if (k == '0 && p == P2) return C2;
    return 256'hbad;
  endfunction

  function automatic logic [255:0] dec_lookup(input logic [255:0] k, input logic [255:0] c);
    if (k == KEY1 && c == C1) return P1;
    return 256'hbad;
  endfunction

  // Cores sample start just before the edge and drop ready right after it.
  always begin
    @(negedge clk); #4;
    s_rst = core_rst; s_enc = core_enc_start; s_dec = core_dec_start;
    s_key = core_key; s_inp = core_inp;
    @(posedge clk); #1;
    if (!s_rst) begin
      core_enc_ready = 1'b0; core_dec_ready = 1'b0; enc_cnt = 0; dec_cnt = 0;
    end else begin
      if (s_enc) begin
        core_enc_ready = 1'b0; enc_cnt = enc_lat; enc_res = enc_lookup(s_key, s_inp);
      end else if (enc_cnt > 0) begin
        enc_cnt--;
        if (enc_cnt == 0 && !stuck) begin core_enc_ready = 1'b1; core_enc_out = enc_res; end
      end
      if (s_dec) begin
        core_dec_ready = 1'b0; dec_cnt = dec_lat; dec_res = dec_lookup(s_key, s_inp);
      end else if (dec_cnt > 0) begin
        dec_cnt--;
        if (dec_cnt == 0 && !stuck) begin core_dec_ready = 1'b1; core_dec_out = dec_res; end
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int grant_q[$];
  int grant_cyc_q[$];
  logic [255:0] rsp_data_q[$];
  int rsp_id_q[$];
  bit rsp_err_q[$];
  int rsp_cyc_q[$];
  int enc_pulses = 0;
  int dec_pulses = 0;
  int core_rst_low = 0;

  always begin
    @(negedge clk); #4;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin grant_q.push_back(i); grant_cyc_q.push_back(cyc); end
      if (rsp_valid && rsp_ready) begin
        rsp_data_q.push_back(rsp_data); rsp_id_q.push_back(int'(rsp_id));
        rsp_err_q.push_back(rsp_err); rsp_cyc_q.push_back(cyc);
      end
      if (core_enc_start) enc_pulses++;
      if (core_dec_start) dec_pulses++;
      if (!core_rst) core_rst_low++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic clear_logs;
    grant_q.delete(); grant_cyc_q.delete();
    rsp_data_q.delete(); rsp_id_q.delete(); rsp_err_q.delete(); rsp_cyc_q.delete();
    enc_pulses = 0; dec_pulses = 0; core_rst_low = 0;
  endtask

  task automatic wait_rsp_valid(input int budget, output int waited, output bit ok);
    waited = 0; ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); waited++; ok = rsp_valid;
    end
  endtask

  task automatic wait_grants(input int cnt, input int budget, output bit ok);
    ok = (grant_q.size() >= cnt);
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); ok = (grant_q.size() >= cnt);
    end
  endtask

  task automatic wait_rsps(input int cnt, input int budget, output bit ok);
    ok = (rsp_id_q.size() >= cnt);
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk); ok = (rsp_id_q.size() >= cnt);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0; rsp_ready = 1'b0; req_valid = '1;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    vectors++; if (rsp_id !== 2'd0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id_err: got id %0d err %b want 0 0", rsp_id, rsp_err); end
    vectors++; if ({core_enc_start, core_dec_start} !== 2'b00) begin miscompares++; $display("FAIL reset_starts: got %b want 00", {core_enc_start, core_dec_start}); end
    vectors++; if (core_key !== '0 || core_inp !== '0) begin miscompares++; $display("FAIL reset_core_operands: got key %h inp %h want 0", core_key, core_inp); end
    vectors++; if (core_rst !== 1'b0) begin miscompares++; $display("FAIL reset_core_rst: got %b want 0", core_rst); end
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("FAIL release_core_rst: got %b want 1", core_rst); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    clear_logs();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_key[i*KEY_SIZE +: KEY_SIZE] = '0;
      req_inp[i*BLOCK_SIZE +: BLOCK_SIZE] = P2;
    end
    req_dec = '0; req_valid = '1;
    wait_grants(5, 200, ok);
    req_valid = '0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_grants: got %0d grants want 5", grant_q.size()); end
    wait_rsps(5, 100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_rsps: got %0d responses want 5", rsp_id_q.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        vectors++; if (grant_q[i] !== i % 4) begin miscompares++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, grant_q[i], i % 4); end
        vectors++; if (rsp_data_q[i] !== C2 || rsp_id_q[i] !== i % 4 || rsp_err_q[i] !== 1'b0) begin
          miscompares++; $display("FAIL b2b_rsp[%0d]: got id %0d err %b data %h want id %0d err 0 data %h", i, rsp_id_q[i], rsp_err_q[i], rsp_data_q[i], i % 4, C2);
        end
      end
      for (int i = 0; i < 4; i++) begin
        vectors++; if (grant_cyc_q[i+1] !== rsp_cyc_q[i] + 1) begin
          miscompares++; $display("FAIL b2b_next_accept[%0d]: got cycle %0d want %0d", i, grant_cyc_q[i+1], rsp_cyc_q[i] + 1);
        end
      end
    end
    vectors++; if (enc_pulses !== 5 || dec_pulses !== 0) begin miscompares++; $display("FAIL b2b_pulses: got enc %0d dec %0d want 5 0", enc_pulses, dec_pulses); end
  endtask

  task automatic test_encrypt;
    bit ok; int waited;
    clear_logs();
    rsp_ready = 1'b0;
    req_key[0 +: KEY_SIZE] = KEY1; req_inp[0 +: BLOCK_SIZE] = P1; req_dec = '0;
    req_valid = 4'b0001;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL enc_req_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    vectors++; if ({core_enc_start, core_dec_start} !== 2'b10) begin miscompares++; $display("FAIL enc_launch_pulse: got %b want 10", {core_enc_start, core_dec_start}); end
    vectors++; if (core_key !== KEY1 || core_inp !== P1) begin miscompares++; $display("FAIL enc_operands: got key %h inp %h want %h %h", core_key, core_inp, KEY1, P1); end
    @(negedge clk);
    vectors++; if (core_enc_start !== 1'b0) begin miscompares++; $display("FAIL enc_pulse_width: got %b want 0", core_enc_start); end
    wait_rsp_valid(50, waited, ok);
    vectors++; if (!ok || waited !== 4) begin miscompares++; $display("FAIL enc_latency: got ok %b waited %0d want ok 1 waited 4", ok, waited); end
    vectors++; if (rsp_data !== C1) begin miscompares++; $display("FAIL enc_data: got %h want %h", rsp_data, C1); end
    vectors++; if (rsp_id !== 2'd0 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL enc_id_err: got %0d %b want 0 0", rsp_id, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL enc_rsp_drop: got %b want 0", rsp_valid); end
    vectors++; if (enc_pulses !== 1 || dec_pulses !== 0) begin miscompares++; $display("FAIL enc_pulses: got enc %0d dec %0d want 1 0", enc_pulses, dec_pulses); end
  endtask

  task automatic test_decrypt;
    bit ok; int waited;
    clear_logs();
    rsp_ready = 1'b1;
    req_key[2*KEY_SIZE +: KEY_SIZE] = KEY1; req_inp[2*BLOCK_SIZE +: BLOCK_SIZE] = C1;
    req_dec = 4'b0100; req_valid = 4'b0100;
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL dec_req_ready: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0; req_dec = '0;
    vectors++; if ({core_enc_start, core_dec_start} !== 2'b01) begin miscompares++; $display("FAIL dec_launch_pulse: got %b want 01", {core_enc_start, core_dec_start}); end
    wait_rsp_valid(50, waited, ok);
    vectors++; if (!ok || rsp_data !== P1) begin miscompares++; $display("FAIL dec_data: got ok %b data %h want %h", ok, rsp_data, P1); end
    vectors++; if (rsp_id !== 2'd2 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL dec_id_err: got %0d %b want 2 0", rsp_id, rsp_err); end
    @(negedge clk);
    vectors++; if (enc_pulses !== 0 || dec_pulses !== 1) begin miscompares++; $display("FAIL dec_pulses: got enc %0d dec %0d want 0 1", enc_pulses, dec_pulses); end
  endtask

  task automatic test_backpressure;
    bit ok; int waited;
    clear_logs();
    rsp_ready = 1'b0;
    req_key[1*KEY_SIZE +: KEY_SIZE] = '0; req_inp[1*BLOCK_SIZE +: BLOCK_SIZE] = P2;
    req_key[3*KEY_SIZE +: KEY_SIZE] = '0; req_inp[3*BLOCK_SIZE +: BLOCK_SIZE] = P2;
    req_dec = '0; req_valid = 4'b1010;
    #1;
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_first_grant: got %b want 1000", req_ready); end
    wait_grants(1, 20, ok);
    req_valid[3] = 1'b0;
    wait_rsp_valid(50, waited, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
    for (int n = 0; n < 10; n++) begin
      vectors++;
      if ({rsp_valid, rsp_id, req_ready} !== {1'b1, 2'd3, 4'b0000} || rsp_data !== C2) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got valid %b id %0d req_ready %b data %h want 1 3 0000 %h", n, rsp_valid, rsp_id, req_ready, rsp_data, C2);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_grants(2, 20, ok);
    req_valid = '0;
    vectors++; if (!ok || rsp_cyc_q.size() < 1) begin miscompares++; $display("FAIL bp_second_grant: got %0d grants want 2", grant_q.size()); end
    else begin
      vectors++; if (grant_q[1] !== 1 || grant_cyc_q[1] !== rsp_cyc_q[0] + 1) begin
        miscompares++; $display("FAIL bp_next_accept: got id %0d cycle %0d want id 1 cycle %0d", grant_q[1], grant_cyc_q[1], rsp_cyc_q[0] + 1);
      end
    end
    wait_rsps(2, 50, ok);
    vectors++; if (!ok || rsp_id_q[1] !== 1 || rsp_data_q[1] !== C2) begin miscompares++; $display("FAIL bp_second_rsp: got ok %b responses %0d want id 1 data %h", ok, rsp_id_q.size(), C2); end
  endtask

  task automatic test_reset_busy;
    bit ok;
    clear_logs();
    enc_lat = 20; rsp_ready = 1'b1;
    req_key[1*KEY_SIZE +: KEY_SIZE] = KEY1; req_inp[1*BLOCK_SIZE +: BLOCK_SIZE] = P1;
    req_dec = '0; req_valid = 4'b0010;
    wait_grants(1, 20, ok);
    req_valid = '0;
    repeat (3) @(negedge clk);
    vectors++; if (!ok || core_key !== KEY1 || core_inp !== P1) begin miscompares++; $display("FAIL rb_busy_operands: got ok %b key %h inp %h want %h %h", ok, core_key, core_inp, KEY1, P1); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({rsp_valid, rsp_err, core_enc_start, core_dec_start, req_ready} !== 8'b0) begin
      miscompares++; $display("FAIL rb_async_ctrl: got %b want 00000000", {rsp_valid, rsp_err, core_enc_start, core_dec_start, req_ready});
    end
    vectors++; if (core_key !== '0 || core_inp !== '0 || rsp_id !== 2'd0 || rsp_data !== '0) begin miscompares++; $display("FAIL rb_async_regs: got key %h inp %h id %0d want 0", core_key, core_inp, rsp_id); end
    vectors++; if (core_rst !== 1'b0) begin miscompares++; $display("FAIL rb_core_rst: got %b want 0", core_rst); end
    repeat (2) @(negedge clk);
    rst = 1'b1; enc_lat = 3;
    @(negedge clk);
    clear_logs();
    req_key[0 +: KEY_SIZE] = KEY1; req_inp[0 +: BLOCK_SIZE] = P1;
    req_key[3*KEY_SIZE +: KEY_SIZE] = '0; req_inp[3*BLOCK_SIZE +: BLOCK_SIZE] = P2;
    req_valid = 4'b1001;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rb_ptr_restart: got %b want 0001", req_ready); end
    wait_grants(1, 20, ok);
    req_valid = '0;
    wait_rsps(1, 50, ok);
    vectors++; if (!ok || rsp_id_q[0] !== 0 || rsp_data_q[0] !== C1) begin miscompares++; $display("FAIL rb_after_reset: got ok %b responses %0d want id 0 data %h", ok, rsp_id_q.size(), C1); end
  endtask

`ifdef SWAN256_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    clear_logs();
    stuck = 1'b1; rsp_ready = 1'b1;
    req_key[2*KEY_SIZE +: KEY_SIZE] = '0; req_inp[2*BLOCK_SIZE +: BLOCK_SIZE] = P2;
    req_dec = '0; req_valid = 4'b0100;
    wait_grants(1, 20, ok);
    req_valid = '0;
    wait_rsps(1, 200, ok);
    stuck = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_rsp: got no response want aborted response"); end
    else begin
      vectors++; if (rsp_err_q[0] !== 1'b1 || rsp_data_q[0] !== '0) begin miscompares++; $display("FAIL to_err_data: got err %b data %h want 1 0", rsp_err_q[0], rsp_data_q[0]); end
      vectors++; if (rsp_cyc_q[0] - grant_cyc_q[0] !== 67) begin miscompares++; $display("FAIL to_latency: got %0d want 67", rsp_cyc_q[0] - grant_cyc_q[0]); end
    end
    vectors++; if (core_rst_low !== 1) begin miscompares++; $display("FAIL to_core_rst_cycles: got %0d want 1", core_rst_low); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_reset_busy();
`ifdef SWAN256_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
